// File: rtl/output_act_buffer.sv
// Output activation buffer: captures P accumulator lanes per beat, applies ReLU/rescale/saturate,
// serialises them through a first-word-fall-through FIFO and marks every M-th word with out_last.
module output_act_buffer #(
  parameter int M     = 8,
  parameter int T     = 12,
  parameter int P     = 1,
  parameter int ACC_W = 24,
  parameter int FRAC  = 0,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P*ACC_W-1:0] in_data,
  input  logic               relu_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [T-1:0]       out_data,
  output logic               out_last
);

  localparam int LPW   = (P > 1) ? $clog2(P) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int EW    = (M > 1) ? $clog2(M) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = $signed({{(ACC_W-T+1){1'b0}}, {(T-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = $signed({{(ACC_W-T+1){1'b1}}, {(T-1){1'b0}}});

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // ReLU, arithmetic rescale and saturation of one accumulator lane
  function automatic logic [T-1:0] act_f(input logic [ACC_W-1:0] x, input logic relu);
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] y;
    logic [T-1:0]            r;
    if (relu && x[ACC_W-1]) begin
      v = '0;
    end else begin
      v = $signed(x);
    end
    y = v >>> FRAC;
    if (y > SAT_MAX) begin
      r = SAT_MAX[T-1:0];
    end else if (y < SAT_MIN) begin
      r = SAT_MIN[T-1:0];
    end else begin
      r = y[T-1:0];
    end
    return r;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [P*ACC_W-1:0]   lanes_r;
  logic [LPW-1:0]       lane_ptr_r;
  logic [T-1:0]         mem_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [EW-1:0]        elem_cnt_r;
  logic [ACC_W-1:0]     cur_lane_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 accept_s;
  logic                 last_lane_s;

  assign in_ready    = reset_n & (state_r == IDLE);
  assign accept_s    = in_valid & in_ready;
  assign full_s      = (count_r == CNT_W'(DEPTH));
  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign out_valid   = ~empty_s;
  assign pop_s       = out_valid & out_ready;
  // A full FIFO may still take a word in the same cycle one leaves it.
  assign push_s      = (state_r == DRAIN) & (~full_s | pop_s);
  assign last_lane_s = (lane_ptr_r == LPW'(P - 1));
  assign out_data    = mem_r[rd_ptr_r];
  assign out_last    = out_valid & (elem_cnt_r == EW'(M - 1));

  // Select the captured lane currently being drained
  always_comb begin
    cur_lane_s = lanes_r[ACC_W-1:0];
    for (int i = 1; i < P; i++) begin
      cur_lane_s = (lane_ptr_r == LPW'(i)) ? lanes_r[i*ACC_W +: ACC_W] : cur_lane_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (push_s && last_lane_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, beat capture and lane pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      lanes_r    <= '0;
      lane_ptr_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        lanes_r    <= in_data;
        lane_ptr_r <= '0;
      end else if (push_s) begin
        lane_ptr_r <= last_lane_s ? {LPW{1'b0}} : lane_ptr_r + LPW'(1);
      end
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= act_f(cur_lane_s, relu_en);
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output word position within the current M-word vector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elem_cnt_r <= '0;
    end else if (pop_s) begin
      elem_cnt_r <= (elem_cnt_r == EW'(M - 1)) ? {EW{1'b0}} : elem_cnt_r + EW'(1);
    end
  end

endmodule

// File: tb/tb_output_act_buffer.sv
// Directed bench for output_act_buffer: default build, FRAC=4 build and P=2 build.
module tb_output_act_buffer;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic        in_valid0, in_ready0, relu0, out_valid0, out_ready0, out_last0;
  logic [23:0] in_data0;
  logic [11:0] out_data0;

  logic        in_valid_f, in_ready_f, relu_f, out_valid_f, out_ready_f, out_last_f;
  logic [23:0] in_data_f;
  logic [11:0] out_data_f;

  logic        in_valid_p, in_ready_p, relu_p, out_valid_p, out_ready_p, out_last_p;
  logic [47:0] in_data_p;
  logic [11:0] out_data_p;

  output_act_buffer dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .relu_en(relu0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_last(out_last0)
  );

  output_act_buffer #(.FRAC(4)) dut_f (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_f), .in_ready(in_ready_f),
    .in_data(in_data_f), .relu_en(relu_f), .out_valid(out_valid_f), .out_ready(out_ready_f),
    .out_data(out_data_f), .out_last(out_last_f)
  );

  output_act_buffer #(.P(2)) dut_p (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_p), .in_ready(in_ready_p),
    .in_data(in_data_p), .relu_en(relu_p), .out_valid(out_valid_p), .out_ready(out_ready_p),
    .out_data(out_data_p), .out_last(out_last_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; beats accepted on this edge are withdrawn, and P-build data is scrambled after capture
  task automatic step();
    logic a0, af, ap;
    a0 = in_valid0 & in_ready0;
    af = in_valid_f & in_ready_f;
    ap = in_valid_p & in_ready_p;
    @(posedge clk);
    #1;
    if (a0) in_valid0 = 1'b0;
    if (af) in_valid_f = 1'b0;
    if (ap) begin
      in_valid_p = 1'b0;
      in_data_p  = 48'hABCDEF_ABCDEF;
    end
  endtask

  task automatic send0(input string tag, input logic [23:0] d, input logic r, input logic [11:0] exp);
    in_data0  = d;
    relu0     = r;
    in_valid0 = 1'b1;
    step();
    step();
    chk({tag, "_valid"}, {31'd0, out_valid0}, 32'd1);
    chk({tag, "_data"}, {20'd0, out_data0}, {20'd0, exp});
  endtask

  task automatic sendf(input string tag, input logic [23:0] d, input logic r, input logic [11:0] exp);
    in_data_f  = d;
    relu_f     = r;
    in_valid_f = 1'b1;
    step();
    step();
    chk({tag, "_data"}, {20'd0, out_data_f}, {20'd0, exp});
  endtask

  initial begin
    int n;
    int b;
    int w;
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    in_valid0 = 1'b0; in_valid_f = 1'b0; in_valid_p = 1'b0;
    in_data0 = 24'd0; in_data_f = 24'd0; in_data_p = 48'd0;
    relu0 = 1'b1; relu_f = 1'b1; relu_p = 1'b1;
    out_ready0 = 1'b1; out_ready_f = 1'b1; out_ready_p = 1'b1;

    step();
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_out_last", {31'd0, out_last0}, 32'd0);
    chk("rst_out_data", {20'd0, out_data0}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("idle_in_ready", {31'd0, in_ready0}, 32'd1);

    // Pass-through latency: nothing visible one edge after acceptance, word after the next
    in_data0  = 24'h000005;
    relu0     = 1'b1;
    in_valid0 = 1'b1;
    step();
    chk("pt_lat_valid", {31'd0, out_valid0}, 32'd0);
    chk("pt_drain_ready", {31'd0, in_ready0}, 32'd0);
    step();
    chk("pt_valid", {31'd0, out_valid0}, 32'd1);
    chk("pt_data", {20'd0, out_data0}, 32'h005);
    chk("pt_ready_back", {31'd0, in_ready0}, 32'd1);

    send0("relu_neg", 24'hFFFFFD, 1'b1, 12'h000);
    send0("sign_neg", 24'hFFFFFD, 1'b0, 12'hFFD);
    send0("sat_pos", 24'h001000, 1'b1, 12'h7FF);
    send0("sat_neg", 24'hFFE000, 1'b0, 12'h800);
    step();
    chk("drained_empty", {31'd0, out_valid0}, 32'd0);

    sendf("frac_pos", 24'h000123, 1'b1, 12'h012);
    sendf("frac_neg", 24'hFFFFF0, 1'b0, 12'hFFF);

    // Backpressure: four words queue, beat 5 stalls in DRAIN, beat 6 is refused
    out_ready0 = 1'b0;
    relu0      = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      in_data0  = 24'(v);
      in_valid0 = 1'b1;
      n = 0;
      while (!in_ready0 && n < 10) begin
        step();
        n++;
      end
      chk("bp_accept", {31'd0, in_ready0}, 32'd1);
      step();
    end
    in_data0  = 24'd6;
    in_valid0 = 1'b1;
    repeat (4) step();
    chk("bp_stall_ready", {31'd0, in_ready0}, 32'd0);
    chk("bp_full_valid", {31'd0, out_valid0}, 32'd1);
    chk("bp_head", {20'd0, out_data0}, 32'd1);
    out_ready0 = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      n = 0;
      while (!out_valid0 && n < 10) begin
        step();
        n++;
      end
      chk("bp_word", {20'd0, out_data0}, 32'(j));
      chk("bp_last", {31'd0, out_last0}, (j == 3) ? 32'd1 : 32'd0);
      step();
    end
    chk("bp_none_extra", {31'd0, out_valid0}, 32'd0);

    // P=2: lanes come out low first, out_last on word 8 only, then the count wraps
    b = 1;
    w = 1;
    n = 0;
    while (w <= 10 && n < 80) begin
      if (in_ready_p && !in_valid_p && b <= 5) begin
        in_data_p  = {24'(b * 2), 24'(b * 2 - 1)};
        in_valid_p = 1'b1;
        b++;
      end
      if (out_valid_p) begin
        chk("lane_word", {20'd0, out_data_p}, 32'(w));
        chk("lane_last", {31'd0, out_last_p}, (w == 8) ? 32'd1 : 32'd0);
        w++;
      end
      step();
      n++;
    end
    chk("lane_count", 32'(w), 32'd11);

    // Reset with three words queued
    out_ready0 = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      in_data0  = 24'(v + 16);
      in_valid0 = 1'b1;
      n = 0;
      while (!in_ready0 && n < 10) begin
        step();
        n++;
      end
      chk("rq_accept", {31'd0, in_ready0}, 32'd1);
      step();
    end
    step();
    chk("rq_queued", {31'd0, out_valid0}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rq_rst_valid", {31'd0, out_valid0}, 32'd0);
    chk("rq_rst_ready", {31'd0, in_ready0}, 32'd0);
    chk("rq_rst_last", {31'd0, out_last0}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rq_post_ready", {31'd0, in_ready0}, 32'd1);
    chk("rq_post_empty", {31'd0, out_valid0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
